mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the CPU data port, downstream of the core's `data_addr`/`data_write`/`data_in`/`data_read` outputs. It decodes a small register window, buffers bytes written by software in a FIFO, and serialises them on `tx` as 8N1 frames. Read data is returned combinationally so the single-cycle core can mux it into `data_out` in the same cycle as the load.

---
 rtl/mmio_uart_tx.sv | 136 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes a 3-word register window, queues
// software-written bytes in a small FIFO and serialises them on tx.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic        mmio_hit,
    output logic [31:0] mmio_rdata,
    output logic        tx,
    output logic        busy
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam int          DW        = $clog2(CLK_DIV);
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] div;

    logic [29:0] word_off;
    logic        sel_txdata, sel_status;
    logic        push_req, push_ok, pop, w1c;
    logic        fifo_full, fifo_empty, div_last;
    logic [31:0] status;
    logic        unused_bits;

    // Offset relative to the base word; addresses below the base wrap to large values.
    assign word_off   = data_addr[31:2] - BASE_WORD;
    assign mmio_hit   = word_off < 30'd3;
    assign sel_txdata = word_off == 30'd0;
    assign sel_status = word_off == 30'd1;

    assign fifo_full  = count == CW'(FIFO_DEPTH);
    assign fifo_empty = count == '0;
    assign div_last   = div == DW'(CLK_DIV - 1);

    // Full is taken from the pre-edge count, so a push to a full FIFO drops even alongside a pop.
    assign push_req = sel_txdata && data_write[0];
    assign push_ok  = push_req && !fifo_full;
    assign w1c      = sel_status && data_write[0] && data_in[3];
    assign pop      = !fifo_empty && (state == IDLE || (state == STOP && div_last));

    assign busy       = (state != IDLE) || !fifo_empty;
    assign status     = {16'h0, 8'(count), 4'h0, overflow, busy, fifo_empty, fifo_full};
    assign mmio_rdata = (data_read && sel_status) ? status : 32'h0;

    assign unused_bits = ^{data_addr[1:0], data_write[3:1], data_in[31:8]};

    // NOTE: storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push_req && fifo_full) overflow <= 1'b1;
            else if (w1c)              overflow <= 1'b0;
        end
    end

    // NOTE: state is non-blocking so every process samples the pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift   <= '0;
            bit_cnt <= '0;
            div     <= '0;
        end else if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            div     <= '0;
        end else if (state != IDLE) begin
            if (div_last) begin
                div <= '0;
                if (state == DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

    // NOTE: default first so no path through the case leaves state_next unassigned.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = START;
            START: if (div_last) state_next = DATA;
            DATA:  if (div_last && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (div_last) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
            default: tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus randomized bus
// traffic compared every cycle against a frame-level behavioural model.
module tb_mmio_uart_tx;
    localparam int          DIV   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam logic [29:0] BW    = BASE[31:2];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_addr = '0;
    logic        data_read = 1'b0;
    logic [3:0]  data_write = '0;
    logic [31:0] data_in = '0;
    logic        mmio_hit;
    logic [31:0] mmio_rdata;
    logic        tx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_addr(data_addr), .data_read(data_read),
        .data_write(data_write), .data_in(data_in), .mmio_hit(mmio_hit),
        .mmio_rdata(mmio_rdata), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the current frame as (byte, cycles elapsed in frame).
    logic [7:0] m_q[$];
    logic [7:0] m_byte = '0;
    int         m_fcyc = -1;
    logic       m_ovf = 1'b0;

    function automatic logic m_tx();
        logic [9:0] frame;
        if (m_fcyc < 0) return 1'b1;
        frame = {1'b1, m_byte, 1'b0};
        return frame[m_fcyc / DIV];
    endfunction

    function automatic logic m_busy();
        return (m_fcyc >= 0) || (m_q.size() != 0);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int sz;
        sz = m_q.size();
        s = '0;
        s[0] = (sz == DEPTH);
        s[1] = (sz == 0);
        s[2] = m_busy();
        s[3] = m_ovf;
        s[15:8] = 8'(sz);
        return s;
    endfunction

    function automatic logic m_hit();
        return (data_addr[31:2] >= BW) && (data_addr[31:2] <= BW + 30'd2);
    endfunction

    function automatic logic [31:0] m_rdata();
        return (data_read && data_addr[31:2] == BW + 30'd1) ? m_status() : 32'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int   sz;
        logic full_b, wr_tx, wr_st;
        if (!rst) begin
            m_q.delete();
            m_fcyc = -1;
            m_ovf  = 1'b0;
        end else begin
            sz     = m_q.size();
            full_b = (sz == DEPTH);
            wr_tx  = data_write[0] && (data_addr[31:2] == BW);
            wr_st  = data_write[0] && (data_addr[31:2] == BW + 30'd1);
            if (m_fcyc == 10 * DIV - 1) m_fcyc = -1;
            else if (m_fcyc >= 0)       m_fcyc++;
            if (m_fcyc < 0 && sz != 0) begin
                m_byte = m_q.pop_front();
                m_fcyc = 0;
            end
            if (wr_tx && full_b)            m_ovf = 1'b1;
            else if (wr_st && data_in[3])   m_ovf = 1'b0;
            if (wr_tx && !full_b) m_q.push_back(data_in[7:0]);
        end
    end

    always @(negedge clk) begin
        check("tx", {31'b0, tx}, {31'b0, m_tx()});
        check("busy", {31'b0, busy}, {31'b0, m_busy()});
        check("hit", {31'b0, mmio_hit}, {31'b0, m_hit()});
        check("rdata", mmio_rdata, m_rdata());
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        data_addr  = a;
        data_in    = d;
        data_write = s;
        @(posedge clk); #1;
        data_write = 4'b0;
    endtask

    task automatic read_status(output logic [31:0] v);
        data_addr = BASE + 32'd4;
        data_read = 1'b1;
        @(negedge clk);
        v = mmio_rdata;
        @(posedge clk); #1;
        data_read = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 200);
        check("start_seen", {31'b0, tx}, 32'h0);
    endtask

    task automatic capture_rest(output logic [9:0] pat);
        pat = '0;
        for (int c = 1; c < 10 * DIV; c++) begin
            @(negedge clk);
            if (c % DIV == DIV / 2) pat[c / DIV] = tx;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_seen", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] v;
        logic [9:0]  pat;
        int          t0, n;

        // Reset held: status reads empty, line idle.
        #1 rst = 1'b0;
        data_addr = BASE + 32'd4;
        data_read = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_status", mmio_rdata, 32'h2);
        check("rst_hit", {31'b0, mmio_hit}, 32'h1);
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        #1 rst = 1'b1;
        data_read = 1'b0;
        data_addr = '0;
        repeat (20) @(negedge clk);
        check("idle_tx", {31'b0, tx}, 32'h1);
        @(posedge clk); #1;

        // Single byte A5.
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        @(negedge clk);
        check("pre_start_tx", {31'b0, tx}, 32'h1);
        @(negedge clk);
        check("start_tx", {31'b0, tx}, 32'h0);
        capture_rest(pat);
        check("frame_a5", {22'b0, pat}, {22'b0, 10'b1_1010_0101_0});
        @(negedge clk);
        check("busy_after_stop", {31'b0, busy}, 32'h0);
        @(posedge clk); #1;

        // Byte strobes.
        bus_write(BASE, 32'h0000_00A5, 4'b1110);
        read_status(v);
        check("strobe_nopush", v, 32'h2);
        bus_write(BASE, 32'hFFFF_FF3C, 4'b0001);
        wait_start();
        capture_rest(pat);
        check("frame_3c", {22'b0, pat}, {22'b0, 1'b1, 8'h3C, 1'b0});
        wait_idle();

        // Full / overflow burst.
        bus_write(BASE, 32'h01, 4'b0001);
        t0 = cyc;
        for (int k = 2; k <= 6; k++) bus_write(BASE, 32'(k), 4'b0001);
        read_status(v);
        check("burst_status", v, 32'h0000_040D);
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("burst_idle", {31'b0, busy}, 32'h0);
        check("burst_cycles", 32'(cyc - t0), 32'(1 + 5 * 10 * DIV));
        @(posedge clk); #1;
        read_status(v);
        check("drain_status", v, 32'h0000_000A);

        // W1C needs both strobe 0 and data bit 3.
        bus_write(BASE + 32'd4, 32'h7, 4'b0001);
        read_status(v);
        check("w1c_needs_bit3", v, 32'hA);
        bus_write(BASE + 32'd4, 32'h8, 4'b0010);
        read_status(v);
        check("w1c_needs_strobe", v, 32'hA);
        bus_write(BASE + 32'd4, 32'h8, 4'b0001);
        read_status(v);
        check("w1c_clear", v, 32'h2);

        // Randomized traffic with write-rate phases; checked each cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r, rate, ph;
            ph   = (i / 250) % 3;
            rate = (ph == 0) ? 3 : ((ph == 1) ? 15 : 60);
            r    = $urandom_range(0, 99);
            data_read  = 1'($urandom_range(0, 1));
            data_in    = $urandom();
            data_write = 4'b0;
            data_addr  = BASE + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(0, 3));
            if (r < rate) begin
                data_addr  = BASE + 32'($urandom_range(0, 3));
                data_write = 4'($urandom_range(0, 15)) | 4'b0001;
            end else if (r < rate + 4) begin
                data_addr  = BASE + 32'd4;
                data_write = 4'($urandom_range(0, 15));
            end else if (r < rate + 8) begin
                data_addr  = BASE + 32'($urandom_range(2, 3)) * 32'd4;
                data_write = 4'($urandom_range(0, 15));
            end else if (r < rate + 10) begin
                data_addr  = $urandom();
                data_write = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
        end
        data_write = 4'b0;
        data_read  = 1'b0;
        wait_idle();

        // Reset in the middle of a frame with a second byte queued.
        bus_write(BASE, 32'h00, 4'b0001);
        bus_write(BASE, 32'h55, 4'b0001);
        wait_start();
        repeat (12) @(negedge clk);
        check("pre_reset_tx", {31'b0, tx}, 32'h0);
        #1 rst = 1'b0;
        data_addr = BASE + 32'd4;
        data_read = 1'b1;
        #1;
        check("reset_tx_now", {31'b0, tx}, 32'h1);
        check("reset_busy_now", {31'b0, busy}, 32'h0);
        check("reset_status_now", mmio_rdata, 32'h2);
        @(negedge clk);
        #1 rst = 1'b1;
        data_read = 1'b0;
        @(posedge clk); #1;
        read_status(v);
        check("post_reset_status", v, 32'h2);

        // Decode edges.
        data_read = 1'b1;
        data_addr = BASE + 32'd12;
        #1;
        check("hit_off12", {31'b0, mmio_hit}, 32'h0);
        check("rdata_off12", mmio_rdata, 32'h0);
        data_addr = BASE + 32'd8;
        #1;
        check("hit_off8", {31'b0, mmio_hit}, 32'h1);
        check("rdata_off8", mmio_rdata, 32'h0);
        data_addr = BASE + 32'd7;
        #1;
        check("rdata_lowbits", mmio_rdata, 32'h2);
        data_addr = BASE - 32'd4;
        #1;
        check("hit_below", {31'b0, mmio_hit}, 32'h0);
        data_read = 1'b0;
        data_addr = BASE + 32'd4;
        #1;
        check("rdata_noread", mmio_rdata, 32'h0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
